// File: rtl/nivel_cxa_monitor_pkg.sv
// Shared definitions for the tank level monitor: 7-segment glyphs, blink phase type and
// small combinational helpers used by the top level.
package nivel_cxa_monitor_pkg;

    // Segment bit indices inside the active-high {P,G,F,E,D,C,B,A} digit bus
    localparam int SEG_A_BIT = 0;
    localparam int SEG_G_BIT = 6;
    localparam int SEG_P_BIT = 7;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        PHASE_OFF = 1'b0,
        PHASE_ON  = 1'b1
    } blink_phase_t;

    function automatic logic [6:0] seg_glyph(input logic [3:0] digit);
        logic [6:0] g;
        case (digit)
            4'd0:    g = SEG_0;
            4'd1:    g = SEG_1;
            4'd2:    g = SEG_2;
            4'd3:    g = SEG_3;
            4'd4:    g = SEG_4;
            4'd5:    g = SEG_5;
            4'd6:    g = SEG_6;
            4'd7:    g = SEG_7;
            4'd8:    g = SEG_8;
            4'd9:    g = SEG_9;
            default: g = SEG_E;
        endcase
        return g;
    endfunction

    // Probe count never exceeds 9, so a fixed 9-bit popcount covers every configuration
    function automatic logic [3:0] popcount9(input logic [8:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 9; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/nivel_cxa_monitor_if.sv
// Probe inputs and display/alarm outputs of the tank level monitor.
interface nivel_cxa_monitor_if #(
    parameter int NUM_SENSORS = 4
) ();
    localparam int LW = $clog2(NUM_SENSORS + 1);

    logic [NUM_SENSORS-1:0] nv_sensor;
    logic [LW-1:0]          level;
    logic                   level_valid;
    logic                   nivel_baixo;
    logic                   nivel_cheio;
    logic                   sensor_fault;
    logic [7:0]             seg;

    modport master (
        output nv_sensor,
        input  level, level_valid, nivel_baixo, nivel_cheio, sensor_fault, seg
    );

    modport slave (
        input  nv_sensor,
        output level, level_valid, nivel_baixo, nivel_cheio, sensor_fault, seg
    );
endinterface

// File: rtl/cxa_debounce.sv
// One probe: 2-FF synchroniser followed by a consecutive-mismatch counter that only
// accepts a new level after DEBOUNCE_CYCLES cycles of agreement.
module cxa_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);
    localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_reg;
    logic          sync_reg;
    logic          stable_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg   <= 1'b0;
            sync_reg   <= 1'b0;
            stable_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            meta_reg <= raw;
            sync_reg <= meta_reg;
            if (sync_reg == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                stable_reg <= sync_reg;
                cnt_reg    <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    assign stable = stable_reg;
endmodule

// File: rtl/nivel_cxa_monitor.sv
// Water-tank level monitor: per-probe debounce, thermometer validation, level encoding,
// alarm flags and a blinking 7-segment digit.
module nivel_cxa_monitor
    import nivel_cxa_monitor_pkg::*;
#(
    parameter int NUM_SENSORS     = 4,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int LOW_LEVEL       = 1,
    parameter int BLINK_CYCLES    = 25000000
) (
    input  logic               clk,
    input  logic               rst,
    nivel_cxa_monitor_if.slave mon
);
    localparam int LW = $clog2(NUM_SENSORS + 1);
    localparam int SW = $clog2(DEBOUNCE_CYCLES + 3);
    localparam int BW = $clog2(BLINK_CYCLES);

    localparam logic [NUM_SENSORS-1:0] ONE_NS       = NUM_SENSORS'(1);
    localparam logic [LW-1:0]          LOW_LW       = LW'(LOW_LEVEL);
    localparam logic [LW-1:0]          FULL_LW      = LW'(NUM_SENSORS);
    localparam logic [SW-1:0]          STARTUP_LAST = SW'(DEBOUNCE_CYCLES + 2);
    localparam logic [BW-1:0]          BLINK_LAST   = BW'(BLINK_CYCLES - 1);

    logic [NUM_SENSORS-1:0] stable;

    generate
        for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_probe
            cxa_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .rst    (rst),
                .raw    (mon.nv_sensor[gi]),
                .stable (stable[gi])
            );
        end
    endgenerate

    logic [LW-1:0] level_reg,       level_next;
    logic          valid_reg,       valid_next;
    logic          fault_reg,       fault_next;
    logic          baixo_reg,       baixo_next;
    logic          cheio_reg,       cheio_next;
    logic [7:0]    seg_reg,         seg_next;
    logic [SW-1:0] startup_cnt_reg, startup_cnt_next;
    logic [BW-1:0] blink_cnt_reg,   blink_cnt_next;
    blink_phase_t  phase_reg,       phase_next;

    logic          legal;
    logic [LW-1:0] pop;
    logic [6:0]    glyph;

    always_comb begin
        // 0..01..1 is exactly the set of vectors with no overlap against themselves plus one
        legal = (stable & (stable + ONE_NS)) == '0;
        pop   = LW'(popcount9(9'(stable)));

        startup_cnt_next = valid_reg ? startup_cnt_reg : startup_cnt_reg + SW'(1);
        valid_next       = valid_reg | (startup_cnt_reg == STARTUP_LAST);

        level_next = legal ? pop : level_reg;
        fault_next = valid_next & ~legal;
        baixo_next = valid_next & legal & (pop <= LOW_LW);
        cheio_next = valid_next & legal & (pop == FULL_LW);

        if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_next = '0;
            phase_next     = (phase_reg == PHASE_ON) ? PHASE_OFF : PHASE_ON;
        end else begin
            blink_cnt_next = blink_cnt_reg + BW'(1);
            phase_next     = phase_reg;
        end

        glyph    = fault_next ? SEG_E : seg_glyph(4'(level_next));
        seg_next = '0;
        if (valid_next) begin
            if ((baixo_next | fault_next) && (phase_next == PHASE_OFF)) begin
                seg_next[SEG_G_BIT:SEG_A_BIT] = SEG_BLANK;
            end else begin
                seg_next[SEG_G_BIT:SEG_A_BIT] = glyph;
            end
            seg_next[SEG_P_BIT] = cheio_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_reg       <= '0;
            valid_reg       <= 1'b0;
            fault_reg       <= 1'b0;
            baixo_reg       <= 1'b0;
            cheio_reg       <= 1'b0;
            seg_reg         <= '0;
            startup_cnt_reg <= '0;
            blink_cnt_reg   <= '0;
            phase_reg       <= PHASE_ON;
        end else begin
            level_reg       <= level_next;
            valid_reg       <= valid_next;
            fault_reg       <= fault_next;
            baixo_reg       <= baixo_next;
            cheio_reg       <= cheio_next;
            seg_reg         <= seg_next;
            startup_cnt_reg <= startup_cnt_next;
            blink_cnt_reg   <= blink_cnt_next;
            phase_reg       <= phase_next;
        end
    end

    assign mon.level        = level_reg;
    assign mon.level_valid  = valid_reg;
    assign mon.sensor_fault = fault_reg;
    assign mon.nivel_baixo  = baixo_reg;
    assign mon.nivel_cheio  = cheio_reg;
    assign mon.seg          = seg_reg;
endmodule

// File: tb/tb_nivel_cxa_monitor.sv
// Directed bench for the tank level monitor: a 4-probe instance for timing/fault cases
// and a 9-probe instance for the full glyph sweep.
module tb_nivel_cxa_monitor;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    nivel_cxa_monitor_if #(.NUM_SENSORS(4)) mon4 ();
    nivel_cxa_monitor_if #(.NUM_SENSORS(9)) mon9 ();

    nivel_cxa_monitor #(
        .NUM_SENSORS(4), .DEBOUNCE_CYCLES(4), .LOW_LEVEL(1), .BLINK_CYCLES(8)
    ) dut4 (
        .clk (clk),
        .rst (rst),
        .mon (mon4)
    );

    nivel_cxa_monitor #(
        .NUM_SENSORS(9), .DEBOUNCE_CYCLES(4), .LOW_LEVEL(1), .BLINK_CYCLES(8)
    ) dut9 (
        .clk (clk),
        .rst (rst),
        .mon (mon9)
    );

    // Edges since reset released; blink phase is on during cycles 0-7, 16-23, ...
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        logic [3:0] sens;
        int         hold;
        int         lvl;
        int         flt;
        int         baixo;
        int         cheio;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [7:0] glyph_model(input int d);
        case (d)
            0: return 8'h3F;
            1: return 8'h06;
            2: return 8'h5B;
            3: return 8'h4F;
            4: return 8'h66;
            5: return 8'h6D;
            6: return 8'h7D;
            7: return 8'h07;
            8: return 8'h7F;
            9: return 8'h6F;
            default: return 8'h79;
        endcase
    endfunction

    function automatic logic [7:0] seg_model(input int lvl, input int valid, input int flt,
                                             input int baixo, input int cheio);
        logic [7:0] g;
        if (valid == 0) return 8'h00;
        g = (flt != 0) ? 8'h79 : glyph_model(lvl);
        if (((baixo != 0) || (flt != 0)) && (((cyc / 8) % 2) != 0)) g = 8'h00;
        g[7] = (cheio != 0);
        return g;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %h expected %h (lvl,valid,fault,low,full,seg)",
                     name, cyc, act, exp);
        end
    endtask

    task automatic check4(input string name, input int lvl, input int valid, input int flt,
                          input int baixo, input int cheio);
        logic [15:0] a, e;
        a = {1'b0, mon4.level, mon4.level_valid, mon4.sensor_fault,
             mon4.nivel_baixo, mon4.nivel_cheio, mon4.seg};
        e = {1'b0, 3'(lvl), valid != 0, flt != 0, baixo != 0, cheio != 0,
             seg_model(lvl, valid, flt, baixo, cheio)};
        check(name, 32'(a), 32'(e));
    endtask

    task automatic check9(input string name, input int lvl, input int valid, input int flt,
                          input int baixo, input int cheio);
        logic [15:0] a, e;
        a = {mon9.level, mon9.level_valid, mon9.sensor_fault,
             mon9.nivel_baixo, mon9.nivel_cheio, mon9.seg};
        e = {4'(lvl), valid != 0, flt != 0, baixo != 0, cheio != 0,
             seg_model(lvl, valid, flt, baixo, cheio)};
        check(name, 32'(a), 32'(e));
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        logic [9:0] therm;

        vecs[0] = '{4'b0111,  8, 3, 0, 0, 0};
        vecs[1] = '{4'b0101, 18, 3, 1, 0, 0};
        vecs[2] = '{4'b0011,  8, 2, 0, 0, 0};
        vecs[3] = '{4'b0001,  8, 1, 0, 1, 0};
        vecs[4] = '{4'b1000, 18, 1, 1, 0, 0};
        vecs[5] = '{4'b0000,  8, 0, 0, 1, 0};
        vecs[6] = '{4'b1111,  8, 4, 0, 0, 1};
        vecs[7] = '{4'b1011,  8, 4, 1, 0, 0};
        vecs[8] = '{4'b1111,  8, 4, 0, 0, 1};

        rst            = 1'b1;
        mon4.nv_sensor = 4'b0000;
        mon9.nv_sensor = 9'h000;
        step();
        check4("reset4", 0, 0, 0, 0, 0);
        check9("reset9", 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;

        // Startup window, then low-level blink of digit 0
        for (int k = 1; k <= 6; k++) begin
            step();
            check4($sformatf("startup_c%0d", k), 0, 0, 0, 0, 0);
        end
        for (int k = 7; k <= 18; k++) begin
            step();
            check4($sformatf("low_blink_c%0d", k), 0, 1, 0, 1, 0);
        end

        // 0000 -> 0111: level appears exactly 7 cycles after the change
        mon4.nv_sensor = 4'b0111;
        for (int k = 1; k <= 6; k++) begin
            step();
            check4($sformatf("rise_wait_%0d", k), 0, 1, 0, 1, 0);
        end
        step();
        check4("rise_lvl3", 3, 1, 0, 0, 0);

        // 3-cycle glitch rejected, 5+ cycle hold accepted
        mon4.nv_sensor = 4'b1111;
        repeat (3) step();
        mon4.nv_sensor = 4'b0111;
        for (int k = 1; k <= 10; k++) begin
            step();
            check4($sformatf("glitch_%0d", k), 3, 1, 0, 0, 0);
        end
        mon4.nv_sensor = 4'b1111;
        for (int k = 1; k <= 6; k++) begin
            step();
            check4($sformatf("hold_wait_%0d", k), 3, 1, 0, 0, 0);
        end
        step();
        check4("hold_lvl4", 4, 1, 0, 0, 1);

        // Table: each vector settles by cycle 7, then checked every cycle to end of hold
        for (int v = 0; v < 9; v++) begin
            mon4.nv_sensor = vecs[v].sens;
            repeat (6) step();
            for (int k = 7; k <= vecs[v].hold; k++) begin
                step();
                check4($sformatf("vec%0d_%b_c%0d", v, vecs[v].sens, k), vecs[v].lvl, 1,
                       vecs[v].flt, vecs[v].baixo, vecs[v].cheio);
            end
        end

        // Mid-operation reset with level 4 held
        rst = 1'b1;
        step();
        check4("rst_mid", 0, 0, 0, 0, 0);
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check4($sformatf("rst_startup_%0d", k), 0, 0, 0, 0, 0);
        end
        step();
        check4("rst_recover", 4, 1, 0, 0, 1);

        // Nine probes: full tank, then sweep of every level
        mon9.nv_sensor = 9'h1FF;
        repeat (8) step();
        check9("full9", 9, 1, 0, 0, 1);
        for (int l = 0; l <= 9; l++) begin
            therm          = (10'd1 << l) - 10'd1;
            mon9.nv_sensor = therm[8:0];
            repeat (8) step();
            check9($sformatf("sweep9_l%0d", l), l, 1, 0, (l <= 1) ? 1 : 0, (l == 9) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
